// File: rtl/leaf_scan_seq.sv
// Walks every leaf of a 2-way instance tree of depth DEPTH in path order and streams
// each leaf's value (value = MUL[k]*value + path bit, per level) on a valid/ready port.
module leaf_scan_seq #(
    parameter int unsigned         DEPTH = 4,
    parameter int unsigned         WIDTH = 32,
    parameter logic [4*DEPTH-1:0]  MULS  = 16'h2344
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] base,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEPTH-1:0] out_path,
    output logic [WIDTH-1:0] out_value,
    output logic             out_last
);

    localparam int unsigned      LVL_W     = $clog2(DEPTH + 1);
    localparam logic [DEPTH-1:0] PATH_ONES = '1;

    typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] acc;
    logic [DEPTH-1:0] path;
    logic [LVL_W-1:0] level;
    logic             calc_last;
    logic             path_full;

    // MUL[k] lives in nibble k; k=0 is the outermost level.
    function automatic logic [3:0] mul_at(input logic [LVL_W-1:0] lvl);
        return 4'(MULS >> {lvl, 2'b00});
    endfunction

    // Bit of the path consumed at this level, MSB first.
    function automatic logic path_bit(input logic [DEPTH-1:0] p, input logic [LVL_W-1:0] lvl);
        return 1'((p << lvl) >> (DEPTH - 1));
    endfunction

    // Multiply-add truncated to WIDTH; overflow wraps.
    function automatic logic [WIDTH-1:0] mac_wrap(input logic [WIDTH-1:0] a,
                                                  input logic [3:0]       m,
                                                  input logic             b);
        return a * WIDTH'(m) + WIDTH'(b);
    endfunction

    assign calc_last = (level == LVL_W'(DEPTH - 1));
    assign path_full = (path == PATH_ONES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = CALC;
                CALC:    if (calc_last) state_nxt = EMIT;
                EMIT:    if (out_ready) state_nxt = path_full ? DONE : CALC;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        out_valid = (state == EMIT);
        out_last  = (state == EMIT) && path_full;
    end

    // Datapath: latched root, running accumulator, leaf path and level counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            acc    <= '0;
            path   <= '0;
            level  <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        acc    <= base;
                        path   <= '0;
                        level  <= '0;
                    end
                end
                CALC: begin
                    acc   <= mac_wrap(acc, mul_at(level), path_bit(path, level));
                    level <= level + LVL_W'(1);
                end
                EMIT: begin
                    if (out_ready && !path_full) begin
                        path  <= path + DEPTH'(1);
                        acc   <= base_q;
                        level <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_path  = path;
    assign out_value = acc;

endmodule

// File: tb/tb_leaf_scan_seq.sv
// Directed bench for leaf_scan_seq: default 32-bit instance plus an 8-bit instance
// for wrap-around behaviour.
module tb_leaf_scan_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, out_ready;
    logic [31:0] base;
    logic        busy, done, out_valid, out_last;
    logic [3:0]  out_path;
    logic [31:0] out_value;

    logic        start8, abort8, out_ready8;
    logic [7:0]  base8;
    logic        busy8, done8, out_valid8, out_last8;
    logic [3:0]  out_path8;
    logic [7:0]  out_value8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leaf_scan_seq #(.DEPTH(4), .WIDTH(32), .MULS(16'h2344)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base(base),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_path(out_path), .out_value(out_value), .out_last(out_last)
    );

    leaf_scan_seq #(.DEPTH(4), .WIDTH(8), .MULS(16'h2344)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .base(base8),
        .busy(busy8), .done(done8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_path(out_path8), .out_value(out_value8), .out_last(out_last8)
    );

    // Reference: multipliers 4,4,3,2 from outermost to innermost level.
    function automatic logic [31:0] model(input logic [31:0] b, input int p);
        int m[4] = '{4, 4, 3, 2};
        logic [31:0] v;
        v = b;
        for (int k = 0; k < 4; k++) v = v * m[k] + ((p >> (3 - k)) & 1);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; out_ready = 0; base = 0;
        start8 = 0; abort8 = 0; out_ready8 = 0; base8 = 0;
        #22;
        checks++;
        if ({busy, done, out_valid, out_last, busy8, done8, out_valid8} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {busy, done, out_valid, out_last, busy8, done8, out_valid8});
        end
        checks++;
        if (out_path !== 4'd0 || out_value !== 32'd0) begin
            errors++; $display("FAIL reset_data got path %0d value %0d want 0 0", out_path, out_value);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL after_reset_idle got busy %b valid %b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_full_scan();
        int cyc, idx, ndone, done_cyc, first_cyc;
        logic chk;
        logic [31:0] vals[16];
        base = 32'd0; out_ready = 1; start = 1;
        cyc = 1; idx = 0; ndone = 0; done_cyc = 0; first_cyc = 0; chk = 0;
        for (int i = 0; i < 16; i++) vals[i] = 32'hDEAD_BEEF;
        for (int i = 0; i < 110; i++) begin
            tick();
            cyc++;
            start = 0;
            if (chk) begin
                chk = 0;
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL start_with_done got busy %b want 0", busy);
                end
            end
            if (out_valid === 1'b1) begin
                if (idx == 0) first_cyc = cyc;
                checks++;
                if (out_path !== idx[3:0]) begin
                    errors++; $display("FAIL scan_path got %0d want %0d", out_path, idx);
                end
                checks++;
                if (out_value !== model(32'd0, idx)) begin
                    errors++; $display("FAIL scan_value path %0d got %0d want %0d", idx, out_value, model(32'd0, idx));
                end
                checks++;
                if (out_last !== (idx == 15)) begin
                    errors++; $display("FAIL scan_last path %0d got %b want %b", idx, out_last, idx == 15);
                end
                if (idx < 16) vals[idx] = out_value;
                idx++;
            end
            if (done === 1'b1) begin
                ndone++; done_cyc = cyc; start = 1; chk = 1;
            end
        end
        start = 0;
        checks++;
        if (idx != 16) begin errors++; $display("FAIL scan_count got %0d want 16", idx); end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL done_pulses got %0d want 1", ndone); end
        checks++;
        if (done_cyc != 82) begin errors++; $display("FAIL done_cycle got %0d want 82", done_cyc); end
        checks++;
        if (first_cyc != 6) begin errors++; $display("FAIL first_valid_cycle got %0d want 6", first_cyc); end
        checks++;
        if (vals[0] !== 32'd0 || vals[1] !== 32'd1 || vals[8] !== 32'd24 || vals[15] !== 32'd33) begin
            errors++; $display("FAIL scan_hand_values got %0d %0d %0d %0d want 0 1 24 33", vals[0], vals[1], vals[8], vals[15]);
        end
    endtask

    task automatic test_base_one();
        base = 32'd1; out_ready = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_path !== 4'd0 || out_value !== 32'd96) begin
            errors++; $display("FAIL base_one got valid %b path %0d value %0d want 1 0 96", out_valid, out_path, out_value);
        end
        abort = 1;
        tick();
        abort = 0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_emit got busy %b valid %b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        base = 32'd0; out_ready = 0; start = 1;
        tick();
        start = 0;
        for (int rec = 0; rec < 3; rec++) begin
            for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
            checks++;
            if (out_valid !== 1'b1 || out_path !== rec[3:0]) begin
                errors++; $display("FAIL bp_pre got valid %b path %0d want 1 %0d", out_valid, out_path, rec);
            end
            out_ready = 1;
            tick();
            out_ready = 0;
        end
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (out_valid !== 1'b1 || out_path !== 4'd3 || out_value !== 32'd3) begin
                errors++; $display("FAIL bp_hold got valid %b path %0d value %0d want 1 3 3", out_valid, out_path, out_value);
            end
            tick();
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup got valid %b want 0", out_valid);
        end
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_path !== 4'd4 || out_value !== 32'd6) begin
            errors++; $display("FAIL bp_next got valid %b path %0d value %0d want 1 4 6", out_valid, out_path, out_value);
        end
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_abort();
        int ndone;
        base = 32'd0; out_ready = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 40 && !(out_valid === 1'b1 && out_path === 4'd4); i++) tick();
        tick();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || out_path !== 4'd5) begin
            errors++; $display("FAIL abort_setup got busy %b valid %b path %0d want 1 0 5", busy, out_valid, out_path);
        end
        abort = 1;
        tick();
        abort = 0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_calc got busy %b valid %b done %b want 0 0 0", busy, out_valid, done);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", ndone); end
        out_ready = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_path !== 4'd0 || out_value !== 32'd0) begin
            errors++; $display("FAIL restart got valid %b path %0d value %0d want 1 0 0", out_valid, out_path, out_value);
        end
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_width8();
        base8 = 8'd255; out_ready8 = 1; start8 = 1;
        tick();
        start8 = 0;
        tick();
        base8 = 8'd0; start8 = 1;
        tick();
        start8 = 0;
        for (int i = 0; i < 20 && out_valid8 !== 1'b1; i++) tick();
        checks++;
        if (out_valid8 !== 1'b1 || out_path8 !== 4'd0 || out_value8 !== 8'd160) begin
            errors++; $display("FAIL w8_first got valid %b path %0d value %0d want 1 0 160", out_valid8, out_path8, out_value8);
        end
        tick();
        for (int i = 0; i < 20 && out_valid8 !== 1'b1; i++) tick();
        checks++;
        if (out_valid8 !== 1'b1 || out_path8 !== 4'd1 || out_value8 !== 8'd161) begin
            errors++; $display("FAIL w8_second got valid %b path %0d value %0d want 1 1 161", out_valid8, out_path8, out_value8);
        end
        abort8 = 1;
        tick();
        abort8 = 0;
        checks++;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL w8_abort got busy %b want 0", busy8); end
    endtask

    task automatic test_reset_mid_emit();
        base = 32'd7; out_ready = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_setup got valid %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_async got valid %b busy %b done %b want 0 0 0", out_valid, busy, done);
        end
        checks++;
        if (out_path !== 4'd0 || out_value !== 32'd0) begin
            errors++; $display("FAIL rst_async_data got path %0d value %0d want 0 0", out_path, out_value);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_after got busy %b done %b want 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_base_one();
        test_backpressure();
        test_abort();
        test_width8();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
